// File: rtl/block_checksum_stage.sv
// Block checksum stage: collects BLOCK_LEN 32-bit words from the upstream
// b_out stream and emits one record per block carrying the wrapping sum
// (x) and the XOR (y) of those words. Reading and writing alternate, so
// the input and output handshakes are never active in the same cycle.

package testfunction2_types;

  // One checksum record; x holds the 32-bit wrapping sum read as signed,
  // y holds the XOR of all words in the block.
  typedef struct packed {
    logic signed [31:0] x;
    logic        [31:0] y;
  } record_t;

endpackage

module block_checksum_stage
  import testfunction2_types::*;
#(
  parameter int unsigned BLOCK_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] b_in,
  input  logic        b_in_sync,
  output logic        b_in_notify,
  output record_t     c_out,
  input  logic        c_out_sync,
  output logic        c_out_notify,
  output logic [15:0] block_cnt
);

  // Index of the word that closes a block. The word index is 8 bits wide
  // because BLOCK_LEN never exceeds 255.
  localparam logic [7:0] LAST_IDX = 8'(BLOCK_LEN - 1);

  typedef enum logic {
    ST_READ  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t      state_q,      state_d;
  logic [31:0] sumAcc_q,     sumAcc_d;
  logic [31:0] xorAcc_q,     xorAcc_d;
  logic [7:0]  wordIdx_q,    wordIdx_d;
  record_t     record_q,     record_d;
  logic [15:0] blockCnt_q,   blockCnt_d;
  logic        bInNotify_q,  bInNotify_d;
  logic        cOutNotify_q, cOutNotify_d;

  logic [31:0] sumNext;
  logic [31:0] xorNext;
  logic        inXfer;
  logic        outXfer;

  // Both handshakes only count when this stage is actually offering; a
  // sync pulse from either neighbour while notify is low has no effect.
  always_comb begin
    inXfer  = bInNotify_q && b_in_sync;
    outXfer = cOutNotify_q && c_out_sync;
    sumNext = sumAcc_q + b_in;
    xorNext = xorAcc_q ^ b_in;
  end

  // Next-state logic: accumulate words while reading, and once the last
  // word of the block arrives, latch the record and switch to offering it.
  // While writing, everything holds until downstream accepts the record.
  always_comb begin
    state_d      = state_q;
    sumAcc_d     = sumAcc_q;
    xorAcc_d     = xorAcc_q;
    wordIdx_d    = wordIdx_q;
    record_d     = record_q;
    blockCnt_d   = blockCnt_q;
    bInNotify_d  = bInNotify_q;
    cOutNotify_d = cOutNotify_q;

    unique case (state_q)
      ST_READ: begin
        if (inXfer) begin
          if (wordIdx_q == LAST_IDX) begin
            record_d.x   = signed'(sumNext);
            record_d.y   = xorNext;
            sumAcc_d     = '0;
            xorAcc_d     = '0;
            wordIdx_d    = '0;
            state_d      = ST_WRITE;
            bInNotify_d  = 1'b0;
            cOutNotify_d = 1'b1;
          end else begin
            sumAcc_d  = sumNext;
            xorAcc_d  = xorNext;
            wordIdx_d = wordIdx_q + 8'd1;
          end
        end
      end

      ST_WRITE: begin
        if (outXfer) begin
          blockCnt_d   = blockCnt_q + 16'd1;
          state_d      = ST_READ;
          bInNotify_d  = 1'b1;
          cOutNotify_d = 1'b0;
        end
      end

      default: begin
        state_d      = ST_READ;
        bInNotify_d  = 1'b1;
        cOutNotify_d = 1'b0;
      end
    endcase
  end

  // State register; reset throws away any partial block and any record
  // that was still waiting for downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_READ;
      sumAcc_q     <= '0;
      xorAcc_q     <= '0;
      wordIdx_q    <= '0;
      record_q     <= '0;
      blockCnt_q   <= '0;
      bInNotify_q  <= 1'b1;
      cOutNotify_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sumAcc_q     <= sumAcc_d;
      xorAcc_q     <= xorAcc_d;
      wordIdx_q    <= wordIdx_d;
      record_q     <= record_d;
      blockCnt_q   <= blockCnt_d;
      bInNotify_q  <= bInNotify_d;
      cOutNotify_q <= cOutNotify_d;
    end
  end

  // Every output comes straight from a register.
  always_comb begin
    b_in_notify  = bInNotify_q;
    c_out_notify = cOutNotify_q;
    c_out        = record_q;
    block_cnt    = blockCnt_q;
  end

endmodule

// File: tb/tb_block_checksum_stage.sv
// Testbench for block_checksum_stage: directed scenarios followed by a
// randomized run. Accepted words feed a block-level reference model that
// pushes expected records into a queue; an independent monitor pops and
// compares every record that downstream accepts.

module tb_block_checksum_stage;
  import testfunction2_types::*;

  localparam int unsigned BLOCK_LEN = 4;

  logic        clk;
  logic        rst;
  logic [31:0] b_in;
  logic        b_in_sync;
  logic        b_in_notify;
  record_t     c_out;
  logic        c_out_sync;
  logic        c_out_notify;
  logic [15:0] block_cnt;

  int          vectors;
  int          miscompares;
  logic        randomMode;

  logic [31:0] wordQ[$];
  logic [63:0] expQ[$];
  logic [15:0] expCnt;

  block_checksum_stage #(.BLOCK_LEN(BLOCK_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .b_in         (b_in),
    .b_in_sync    (b_in_sync),
    .b_in_notify  (b_in_notify),
    .c_out        (c_out),
    .c_out_sync   (c_out_sync),
    .c_out_notify (c_out_notify),
    .block_cnt    (block_cnt)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: once a full block of accepted words is collected,
  // the expected record is their plain sum (mod 2^32) and XOR.
  task automatic modelWord(input logic [31:0] word);
    logic [31:0] s;
    logic [31:0] x;
    wordQ.push_back(word);
    if (wordQ.size() == BLOCK_LEN) begin
      s = 0;
      x = 0;
      foreach (wordQ[i]) begin
        s = s + wordQ[i];
        x = x ^ wordQ[i];
      end
      expQ.push_back({s, x});
      wordQ.delete();
    end
  endtask

  // Advance one cycle; in random mode downstream readiness is reshuffled.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (randomMode) c_out_sync = ($urandom_range(0, 3) != 0);
  endtask

  // Offer one word and wait (bounded) until the stage takes it.
  task automatic applyStimulus(input logic [31:0] word);
    bit accepted;
    accepted  = 0;
    b_in      = word;
    b_in_sync = 1'b1;
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge clk);
      if (b_in_notify) begin
        modelWord(word);
        accepted = 1;
      end
      stepCycle();
    end
    b_in_sync = 1'b0;
    if (!accepted) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL input_timeout: got no accept, expected accept of 0x%08h", word);
    end
  endtask

  // Assert reset mid-cycle and check it acts without waiting for a clock.
  task automatic pulseReset();
    rst = 1'b1;
    wordQ.delete();
    expQ.delete();
    expCnt = 16'd0;
    #2;
    checkOutput("rst.b_in_notify", {31'd0, b_in_notify}, 32'd1);
    checkOutput("rst.c_out_notify", {31'd0, c_out_notify}, 32'd0);
    checkOutput("rst.c_out.x", c_out.x, 32'd0);
    checkOutput("rst.c_out.y", c_out.y, 32'd0);
    checkOutput("rst.block_cnt", {16'd0, block_cnt}, 32'd0);
    stepCycle();
    rst = 1'b0;
  endtask

  // Monitor: whenever a record is accepted, compare it with the oldest
  // expected record and check the delivered-block count before increment.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && c_out_notify && c_out_sync) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_record: got x=0x%08h y=0x%08h, expected none",
                   c_out.x, c_out.y);
        end else begin
          exp = expQ.pop_front();
          checkOutput("mon.x", c_out.x, exp[63:32]);
          checkOutput("mon.y", c_out.y, exp[31:0]);
          checkOutput("mon.block_cnt", {16'd0, block_cnt}, {16'd0, expCnt});
          expCnt = expCnt + 16'd1;
        end
      end
    end
  end

  initial begin
    logic [31:0] bpY;
    logic [15:0] cntHold;
    vectors     = 0;
    miscompares = 0;
    randomMode  = 1'b0;
    expCnt      = 16'd0;
    b_in        = '0;
    b_in_sync   = 1'b0;
    c_out_sync  = 1'b1;
    rst         = 1'b0;
    #3;

    pulseReset();
    stepCycle();

    // Basic block 1,2,3,4: record visible one cycle after the last word.
    applyStimulus(32'd1);
    applyStimulus(32'd2);
    applyStimulus(32'd3);
    applyStimulus(32'd4);
    checkOutput("b1.c_out_notify", {31'd0, c_out_notify}, 32'd1);
    checkOutput("b1.b_in_notify", {31'd0, b_in_notify}, 32'd0);
    checkOutput("b1.x", c_out.x, 32'd10);
    checkOutput("b1.y", c_out.y, 32'd4);
    stepCycle();
    checkOutput("b1.block_cnt", {16'd0, block_cnt}, 32'd1);
    checkOutput("b1.b_in_notify_after", {31'd0, b_in_notify}, 32'd1);
    checkOutput("b1.retained_x", c_out.x, 32'd10);

    // Sum wraps modulo 2^32.
    applyStimulus(32'hFFFF_FFFF);
    applyStimulus(32'd1);
    applyStimulus(32'd0);
    applyStimulus(32'd0);
    checkOutput("wrap.x", c_out.x, 32'd0);
    checkOutput("wrap.y", c_out.y, 32'hFFFF_FFFE);
    stepCycle();

    // Backpressure: downstream stalls while upstream keeps offering a word.
    c_out_sync = 1'b0;
    applyStimulus(32'd100);
    applyStimulus(32'd200);
    applyStimulus(32'd300);
    applyStimulus(32'd400);
    bpY       = 32'd100 ^ 32'd200 ^ 32'd300 ^ 32'd400;
    cntHold   = block_cnt;
    b_in      = 32'hDEAD_BEEF;
    b_in_sync = 1'b1;
    for (int c = 0; c < 5; c++) begin
      stepCycle();
      checkOutput("bp.x", c_out.x, 32'd1000);
      checkOutput("bp.y", c_out.y, bpY);
      checkOutput("bp.b_in_notify", {31'd0, b_in_notify}, 32'd0);
      checkOutput("bp.c_out_notify", {31'd0, c_out_notify}, 32'd1);
      checkOutput("bp.block_cnt", {16'd0, block_cnt}, {16'd0, cntHold});
    end
    b_in_sync  = 1'b0;
    c_out_sync = 1'b1;
    stepCycle();
    checkOutput("bp.block_cnt_after", {16'd0, block_cnt}, 32'd3);

    // Words offered during the stall were not absorbed.
    applyStimulus(32'd5);
    applyStimulus(32'd5);
    applyStimulus(32'd5);
    applyStimulus(32'd5);
    checkOutput("five.x", c_out.x, 32'd20);
    checkOutput("five.y", c_out.y, 32'd0);
    stepCycle();

    // Reset mid-block discards the partial words.
    applyStimulus(32'd55);
    applyStimulus(32'd66);
    pulseReset();
    applyStimulus(32'd7);
    applyStimulus(32'd8);
    applyStimulus(32'd9);
    applyStimulus(32'd10);
    checkOutput("rstblk.x", c_out.x, 32'd34);
    checkOutput("rstblk.y", c_out.y, 32'd7 ^ 32'd8 ^ 32'd9 ^ 32'd10);
    stepCycle();
    checkOutput("rstblk.block_cnt", {16'd0, block_cnt}, 32'd1);

    // Reset while a record is pending drops it without counting it.
    c_out_sync = 1'b0;
    for (int w = 0; w < BLOCK_LEN; w++) applyStimulus($urandom);
    pulseReset();
    c_out_sync = 1'b1;

    // Randomized run: random words, idle gaps and downstream stalls.
    randomMode = 1'b1;
    for (int blk = 0; blk < 40; blk++) begin
      for (int w = 0; w < BLOCK_LEN; w++) begin
        repeat ($urandom_range(0, 2)) stepCycle();
        applyStimulus($urandom);
      end
    end
    randomMode = 1'b0;
    c_out_sync = 1'b1;
    for (int k = 0; k < 50 && expQ.size() != 0; k++) stepCycle();
    stepCycle();
    checkOutput("final.pending", expQ.size(), 32'd0);
    checkOutput("final.block_cnt", {16'd0, block_cnt}, {16'd0, expCnt});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
